// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - opcode encodings shared by the pipelined CLA adder/subtractor
package cla_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit lookahead slice: sum for a fixed carry-in plus group G/P
module cla_group #(
    parameter int GROUP = 8
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] sum,
    output logic             g,
    output logic             p
);

    logic [GROUP-1:0] bit_g;
    logic [GROUP-1:0] bit_p;
    logic [GROUP:0]   c;
    logic             g_acc;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    always_comb begin
        c     = '0;
        c[0]  = c_in;
        g_acc = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = bit_g[i] | (bit_p[i] & c[i]);
            g_acc  = bit_g[i] | (bit_p[i] & g_acc);
        end
    end

    assign sum = bit_p ^ c[GROUP-1:0];
    assign g   = g_acc;
    assign p   = &bit_p;

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - 2-stage carry-select/lookahead add/sub (ADD/SUB/ADC/SBB) with flags
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [TAG_W-1:0] tag_out
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_width_check
        $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP");
    end

    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH-1:0] sum0, sum1;
    logic [NG-1:0]    g0, p0, g1, p1;

    always_comb begin
        bx = b;
        c0 = 1'b0;
        case (op)
            OP_ADD: begin bx = b;  c0 = 1'b0; end
            OP_SUB: begin bx = ~b; c0 = 1'b1; end
            OP_ADC: begin bx = b;  c0 = cin;  end
            OP_SBB: begin bx = ~b; c0 = cin;  end
            default: begin bx = b; c0 = 1'b0; end
        endcase
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp0 (
            .a(a[k*GROUP +: GROUP]), .b(bx[k*GROUP +: GROUP]), .c_in(1'b0),
            .sum(sum0[k*GROUP +: GROUP]), .g(g0[k]), .p(p0[k])
        );
        cla_group #(.GROUP(GROUP)) u_grp1 (
            .a(a[k*GROUP +: GROUP]), .b(bx[k*GROUP +: GROUP]), .c_in(1'b1),
            .sum(sum1[k*GROUP +: GROUP]), .g(g1[k]), .p(p1[k])
        );
    end

    logic             s1_valid, s2_valid;
    logic [NG-1:0]    s1_g, s1_p;
    logic [WIDTH-1:0] s1_sum0, s1_sum1;
    logic             s1_c0, s1_amsb, s1_bmsb;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_adv, s2_adv;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Both group copies yield identical G/P (independent of c_in); one is taken from each.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_c0    <= 1'b0;
            s1_amsb  <= 1'b0;
            s1_bmsb  <= 1'b0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_g    <= g0;
                s1_p    <= p1;
                s1_sum0 <= sum0;
                s1_sum1 <= sum1;
                s1_c0   <= c0;
                s1_amsb <= a[WIDTH-1];
                s1_bmsb <= bx[WIDTH-1];
                s1_tag  <= tag;
            end
        end
    end

    logic [NG:0]      gc;
    logic             acc, prod;
    logic [WIDTH-1:0] sel_sum;

    // Second-level lookahead: each group carry is an OR of generate terms propagated upward.
    always_comb begin
        gc    = '0;
        gc[0] = s1_c0;
        acc   = 1'b0;
        prod  = 1'b1;
        for (int k = 0; k < NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc  = acc | (s1_g[j] & prod);
                prod = prod & s1_p[j];
            end
            gc[k+1] = acc | (prod & s1_c0);
        end
        sel_sum = '0;
        for (int k = 0; k < NG; k++) begin
            sel_sum[k*GROUP +: GROUP] = gc[k] ? s1_sum1[k*GROUP +: GROUP]
                                              : s1_sum0[k*GROUP +: GROUP];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            tag_out  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result   <= sel_sum;
                carry    <= gc[NG];
                overflow <= (s1_amsb == s1_bmsb) && (sel_sum[WIDTH-1] != s1_amsb);
                zero     <= (sel_sum == '0);
                negative <= sel_sum[WIDTH-1];
                tag_out  <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule
